// File: rtl/axil_regfile_pkg.sv
// Shared definitions for the AXI-lite slave register file.
//   RESP_OKAY / RESP_SLVERR : 1-bit response encodings used on B and R.
//   rd_state_t              : read channel FSM states.
//   reg_idx()               : byte address -> register (word) index.
package axil_regfile_pkg;

  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_t;

  // Callers zero-extend their ADDR_WIDTH-bit address, so the result equals
  // addr[ADDR_WIDTH-1:2]; the two byte-lane bits are dropped.
  function automatic logic [31:0] reg_idx(input logic [31:0] addr);
    return addr >> 2;
  endfunction

endpackage

// File: rtl/axil_wr_collector.sv
// Write address / write data collector for the AXI-lite register file.
// AW and W are accepted independently (either order or same cycle) and held
// until the pair commits; commit fires when both are held and the B channel
// can take a new response.
//   clk, rst_n      : clock, asynchronous active-low reset
//   waddr/wavalid/waready : write address channel
//   wdata/wvalid/wready   : write data channel
//   commit_ready    : B channel is free (or being drained this cycle)
//   commit          : one-cycle strobe, the held pair is consumed this edge
//   commit_addr/commit_data : latched address and data of the held pair
module axil_wr_collector
  import axil_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic                  wavalid,
  output logic                  waready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic                  commit_ready,
  output logic                  commit,
  output logic [ADDR_WIDTH-1:0] commit_addr,
  output logic [DATA_WIDTH-1:0] commit_data
);

  logic                  aw_held_reg;
  logic                  w_held_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] data_reg;

  assign waready     = !aw_held_reg;
  assign wready      = !w_held_reg;
  assign commit      = aw_held_reg && w_held_reg && commit_ready;
  assign commit_addr = addr_reg;
  assign commit_data = data_reg;

  // While a flag is set its ready is low, so a new beat can never be accepted
  // on the same edge that the held pair commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      addr_reg    <= '0;
      data_reg    <= '0;
    end else if (commit) begin
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
    end else begin
      if (wavalid && !aw_held_reg) begin
        aw_held_reg <= 1'b1;
        addr_reg    <= waddr;
      end
      if (wvalid && !w_held_reg) begin
        w_held_reg <= 1'b1;
        data_reg   <= wdata;
      end
    end
  end

endmodule

// File: rtl/axil_slave_regfile.sv
// AXI-lite slave register bank: NUM_REGS words, each either read/write
// (software owned) or read-only (hardware status taken from hw_i).
//   clk, rst_n             : clock, asynchronous active-low reset
//   waddr/wavalid/waready, wdata/wvalid/wready : write address/data channels
//   wresp/bvalid/bready    : write response channel (1 = SLVERR)
//   raddr/arvalid/arready  : read address channel
//   rdata/rresp/rvalid/rready : read data channel (1 = SLVERR)
//   reg_o      : flattened register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   hw_i       : hardware values for read-only registers
//   wr_pulse_o : one-cycle pulse per register on a committed write
module axil_slave_regfile
  import axil_regfile_pkg::*;
#(
  parameter int                   DATA_WIDTH = 32,
  parameter int                   ADDR_WIDTH = 4,
  parameter int                   NUM_REGS   = 4,
  parameter logic [NUM_REGS-1:0]  RO_MASK    = 4'b1000,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          waddr,
  input  logic                           wavalid,
  output logic                           waready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic                           wvalid,
  output logic                           wready,
  output logic                           wresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          raddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_i,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  // ---------------------------------------------------------------- write path
  logic                  commit;
  logic [ADDR_WIDTH-1:0] commit_addr;
  logic [DATA_WIDTH-1:0] commit_data;
  logic                  bvalid_reg;
  logic                  wresp_reg;
  logic [NUM_REGS-1:0]   wr_pulse_reg;

  axil_wr_collector #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wr_collector (
    .clk          (clk),
    .rst_n        (rst_n),
    .waddr        (waddr),
    .wavalid      (wavalid),
    .waready      (waready),
    .wdata        (wdata),
    .wvalid       (wvalid),
    .wready       (wready),
    .commit_ready (!bvalid_reg || bready),
    .commit       (commit),
    .commit_addr  (commit_addr),
    .commit_data  (commit_data)
  );

  logic [31:0]         wr_idx;
  logic [31:0]         rd_idx;
  logic [NUM_REGS-1:0] wr_hit;
  logic [NUM_REGS-1:0] rd_hit;
  logic [NUM_REGS-1:0] wr_sel;
  logic [DATA_WIDTH-1:0] reg_val [NUM_REGS];

  assign wr_idx = reg_idx(32'(commit_addr));
  assign rd_idx = reg_idx(32'(raddr));
  // Hit vectors are one-hot or all-zero; all-zero means out of range.
  assign wr_sel = wr_hit & ~RO_MASK;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    assign wr_hit[gi] = (wr_idx == 32'(gi));
    assign rd_hit[gi] = (rd_idx == 32'(gi));

    if (RO_MASK[gi]) begin : g_ro
      assign reg_val[gi] = hw_i[gi*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] data_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_reg <= RESET_VAL;
        end else if (commit && wr_hit[gi]) begin
          data_reg <= commit_data;
        end
      end
      assign reg_val[gi] = data_reg;
    end

    assign reg_o[gi*DATA_WIDTH +: DATA_WIDTH] = reg_val[gi];
  end

  // hw_i slices belonging to RW registers are intentionally ignored.
  logic unused_hw;
  assign unused_hw = ^hw_i;

  // B channel. A new commit may land on the same edge bready drains the old
  // response, giving back-to-back B beats with bvalid never dropping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bvalid_reg   <= 1'b0;
      wresp_reg    <= RESP_OKAY;
      wr_pulse_reg <= '0;
    end else begin
      wr_pulse_reg <= commit ? wr_sel : '0;
      if (commit) begin
        bvalid_reg <= 1'b1;
        wresp_reg  <= (|wr_sel) ? RESP_OKAY : RESP_SLVERR;
      end else if (bready) begin
        bvalid_reg <= 1'b0;
      end
    end
  end

  assign bvalid     = bvalid_reg;
  assign wresp      = wresp_reg;
  assign wr_pulse_o = wr_pulse_reg;

  // ----------------------------------------------------------------- read path
  rd_state_t             state_reg;
  rd_state_t             state_next;
  logic                  rd_capture;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic                  rresp_reg;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_hit[i]) rd_word = reg_val[i];
    end
  end

  always_comb begin
    state_next = state_reg;
    rd_capture = 1'b0;
    case (state_reg)
      R_IDLE: begin
        if (arvalid) begin
          rd_capture = 1'b1;
          state_next = R_RESP;
        end
      end
      R_RESP: begin
        if (rready) state_next = R_IDLE;
      end
      default: state_next = R_IDLE;
    endcase
  end

  // Capture uses the stored value before any same-edge write commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= R_IDLE;
      rdata_reg <= '0;
      rresp_reg <= RESP_OKAY;
    end else begin
      state_reg <= state_next;
      if (rd_capture) begin
        rdata_reg <= rd_word;
        rresp_reg <= (|rd_hit) ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign arready = (state_reg == R_IDLE);
  assign rvalid  = (state_reg == R_RESP);
  assign rdata   = rdata_reg;
  assign rresp   = rresp_reg;

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Directed bench for axil_slave_regfile (default parameters).
// Inputs change and outputs are sampled on the falling edge.
module tb_axil_slave_regfile;

  logic         clk;
  logic         rst_n;
  logic [3:0]   waddr;
  logic         wavalid;
  logic         waready;
  logic [31:0]  wdata;
  logic         wvalid;
  logic         wready;
  logic         wresp;
  logic         bvalid;
  logic         bready;
  logic [3:0]   raddr;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic         rresp;
  logic         rvalid;
  logic         rready;
  logic [127:0] reg_o;
  logic [127:0] hw_i;
  logic [3:0]   wr_pulse_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  axil_slave_regfile dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .waddr      (waddr),
    .wavalid    (wavalid),
    .waready    (waready),
    .wdata      (wdata),
    .wvalid     (wvalid),
    .wready     (wready),
    .wresp      (wresp),
    .bvalid     (bvalid),
    .bready     (bready),
    .raddr      (raddr),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready),
    .reg_o      (reg_o),
    .hw_i       (hw_i),
    .wr_pulse_o (wr_pulse_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else pass_cnt++;
  endtask

  // AW and W presented in the same cycle, bready high.
  task automatic write_same(input string tag, input logic [3:0] addr, input logic [31:0] data,
                            input logic exp_resp, input logic [3:0] exp_pulse);
    @(negedge clk);
    waddr = addr; wavalid = 1'b1; wdata = data; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    wavalid = 1'b0; wvalid = 1'b0;
    check({tag, " waready held"}, waready, 1'b0);
    check({tag, " bvalid early"}, bvalid, 1'b0);
    @(negedge clk);
    check({tag, " bvalid"}, bvalid, 1'b1);
    check({tag, " wresp"}, wresp, exp_resp);
    check({tag, " wr_pulse"}, wr_pulse_o, exp_pulse);
    $display("write %s addr=%h data=%h wresp=%0d pulse=%b", tag, addr, data, wresp, wr_pulse_o);
  endtask

  task automatic read_chk(input string tag, input logic [3:0] addr, input logic [31:0] exp_data,
                          input logic exp_resp);
    @(negedge clk);
    raddr = addr; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    arvalid = 1'b0;
    check({tag, " rvalid"}, rvalid, 1'b1);
    check({tag, " rdata"}, rdata, exp_data);
    check({tag, " rresp"}, rresp, exp_resp);
    check({tag, " arready busy"}, arready, 1'b0);
    $display("read  %s addr=%h rdata=%h rresp=%0d", tag, addr, rdata, rresp);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check({tag, " rvalid drop"}, rvalid, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; waddr = '0; wavalid = 1'b0; wdata = '0; wvalid = 1'b0;
    bready = 1'b1; raddr = '0; arvalid = 1'b0; rready = 1'b0;
    hw_i = {32'hA5A5A5A5, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst waready", waready, 1'b1);
    check("rst wready", wready, 1'b1);
    check("rst arready", arready, 1'b1);
    check("rst bvalid", bvalid, 1'b0);
    check("rst rvalid", rvalid, 1'b0);
    check("rst rdata", rdata, 32'h0);
    check("rst wr_pulse", wr_pulse_o, 4'b0000);
    check("rst rw regs", reg_o[95:0], 96'h0);
    rst_n = 1'b1;

    // Same-cycle AW/W to register 1
    write_same("t1", 4'h4, 32'hCAFEF00D, 1'b0, 4'b0010);
    check("t1 reg1", reg_o[63:32], 32'hCAFEF00D);
    @(negedge clk);
    check("t1 bvalid drop", bvalid, 1'b0);
    check("t1 pulse drop", wr_pulse_o, 4'b0000);
    read_chk("t1", 4'h4, 32'hCAFEF00D, 1'b0);
    read_chk("unaligned", 4'h6, 32'hCAFEF00D, 1'b0);

    // W three cycles ahead of AW
    @(negedge clk);
    wdata = 32'h11; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    check("t2 wready held", wready, 1'b0);
    check("t2 waready free", waready, 1'b1);
    @(negedge clk);
    check("t2 no commit a", bvalid, 1'b0);
    @(negedge clk);
    check("t2 no commit b", wr_pulse_o, 4'b0000);
    waddr = 4'h8; wavalid = 1'b1;
    @(negedge clk);
    wavalid = 1'b0;
    check("t2 bvalid early", bvalid, 1'b0);
    @(negedge clk);
    check("t2 bvalid", bvalid, 1'b1);
    check("t2 wresp", wresp, 1'b0);
    check("t2 wr_pulse", wr_pulse_o, 4'b0100);
    check("t2 reg2", reg_o[95:64], 32'h11);
    $display("write t2 addr=8 data=11 wresp=%0d pulse=%b", wresp, wr_pulse_o);

    // Write to the read-only register
    write_same("t3", 4'hC, 32'h5, 1'b1, 4'b0000);
    check("t3 ro mirror", reg_o[127:96], 32'hA5A5A5A5);
    read_chk("t3", 4'hC, 32'hA5A5A5A5, 1'b0);
    hw_i[127:96] = 32'h12345678;
    #1;
    check("t3 ro live", reg_o[127:96], 32'h12345678);

    // B back-pressure with a second pair collected behind it
    @(negedge clk);
    bready = 1'b0;
    waddr = 4'h0; wdata = 32'h100; wavalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    waddr = 4'h4; wdata = 32'h200;
    check("t4 waready held", waready, 1'b0);
    @(negedge clk);
    check("t4 first bvalid", bvalid, 1'b1);
    check("t4 first pulse", wr_pulse_o, 4'b0001);
    check("t4 reg0", reg_o[31:0], 32'h100);
    check("t4 readies back", {waready, wready}, 2'b11);
    @(negedge clk);
    wavalid = 1'b0; wvalid = 1'b0;
    check("t4 both held", {waready, wready}, 2'b00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4 bvalid stall", bvalid, 1'b1);
      check("t4 wresp stall", wresp, 1'b0);
      check("t4 reg1 pending", reg_o[63:32], 32'hCAFEF00D);
    end
    bready = 1'b1;
    @(negedge clk);
    check("t4 second bvalid", bvalid, 1'b1);
    check("t4 second pulse", wr_pulse_o, 4'b0010);
    check("t4 reg1", reg_o[63:32], 32'h200);
    check("t4 reg0 kept", reg_o[31:0], 32'h100);
    $display("write t4 back-to-back reg0=%h reg1=%h", reg_o[31:0], reg_o[63:32]);
    @(negedge clk);
    check("t4 bvalid drop", bvalid, 1'b0);

    // R back-pressure and same-edge write/read of register 0
    @(negedge clk);
    waddr = 4'h0; wdata = 32'h77; wavalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    wavalid = 1'b0; wvalid = 1'b0;
    raddr = 4'h0; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    arvalid = 1'b0;
    check("t5 rvalid", rvalid, 1'b1);
    check("t5 old value", rdata, 32'h100);
    check("t5 reg0 new", reg_o[31:0], 32'h77);
    check("t5 pulse", wr_pulse_o, 4'b0001);
    $display("read  t5 addr=0 rdata=%h (same-edge write 77)", rdata);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5 rvalid stall", rvalid, 1'b1);
      check("t5 rdata stall", rdata, 32'h100);
      check("t5 arready stall", arready, 1'b0);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check("t5 rvalid drop", rvalid, 1'b0);
    check("t5 arready back", arready, 1'b1);
    read_chk("t5 new", 4'h0, 32'h77, 1'b0);

    // Reset with B and R both pending
    @(negedge clk);
    bready = 1'b0;
    waddr = 4'h8; wdata = 32'h99; wavalid = 1'b1; wvalid = 1'b1;
    raddr = 4'h4; arvalid = 1'b1;
    @(negedge clk);
    wavalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    check("t6 bvalid pend", bvalid, 1'b1);
    check("t6 rvalid pend", rvalid, 1'b1);
    check("t6 rdata pend", rdata, 32'h200);
    check("t6 reg2", reg_o[95:64], 32'h99);
    #2 rst_n = 1'b0;
    #1;
    check("t6 bvalid rst", bvalid, 1'b0);
    check("t6 rvalid rst", rvalid, 1'b0);
    check("t6 readies rst", {waready, wready, arready}, 3'b111);
    check("t6 regs rst", reg_o, {32'h12345678, 96'h0});
    $display("reset t6 bvalid=%0d rvalid=%0d reg_o=%h", bvalid, rvalid, reg_o);
    @(negedge clk);
    rst_n = 1'b1; bready = 1'b1;
    read_chk("t6 reg2", 4'h8, 32'h0, 1'b0);
    read_chk("t6 reg0", 4'h0, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
